// File: rtl/apu_aram_arbiter_if.sv
// Bus bundle between the SMP, the DSP fetch/register port, the external audio RAM
// and the ARAM arbiter. The arbiter sits on the slave side; the surrounding system
// (SMP core, DSP, memory controller or a testbench) uses the master side.
interface apu_aram_arbiter_if;

  // SMP bus cycle
  logic        SMP_REQ;
  logic [15:0] SMP_A;
  logic [7:0]  SMP_DO;
  logic        SMP_WE_N;
  logic [7:0]  SMP_DI;
  logic        SMP_WAIT;

  // DSP sample/echo fetch port
  logic        DSP_REQ;
  logic [15:0] DSP_A;
  logic        DSP_ACK;
  logic [7:0]  DSP_DI;

  // DSP register window
  logic [6:0]  REG_ADDR;
  logic        REG_WR;
  logic [7:0]  REG_WDATA;
  logic [7:0]  REG_RDATA;

  // Single-port external memory
  logic        MEM_REQ;
  logic [15:0] MEM_A;
  logic        MEM_WE;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA;
  logic        MEM_ACK;

  // Arbiter view
  modport slave (
    input  SMP_REQ, SMP_A, SMP_DO, SMP_WE_N,
    output SMP_DI, SMP_WAIT,
    input  DSP_REQ, DSP_A,
    output DSP_ACK, DSP_DI,
    output REG_ADDR, REG_WR, REG_WDATA,
    input  REG_RDATA,
    output MEM_REQ, MEM_A, MEM_WE, MEM_WDATA,
    input  MEM_RDATA, MEM_ACK
  );

  // System / environment view
  modport master (
    output SMP_REQ, SMP_A, SMP_DO, SMP_WE_N,
    input  SMP_DI, SMP_WAIT,
    output DSP_REQ, DSP_A,
    input  DSP_ACK, DSP_DI,
    input  REG_ADDR, REG_WR, REG_WDATA,
    output REG_RDATA,
    input  MEM_REQ, MEM_A, MEM_WE, MEM_WDATA,
    output MEM_RDATA, MEM_ACK
  );

endinterface

// File: rtl/apu_aram_arbiter.sv
// ARAM arbiter: shares the 64 KB audio RAM between the SMP bus and the DSP fetch
// port, and decodes the DSP register window at $00F2 (address latch) / $00F3 (data).
// DSP fetches win any tie unless the previous grant went to the DSP, so the two
// requesters alternate under contention and neither waits more than one transaction.
module apu_aram_arbiter (
  input  logic              CLK,
  input  logic              RST_N,
  apu_aram_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {
    StIdle,
    StMemSmp,
    StMemDsp,
    StSmpDone
  } state_e;

  localparam logic [15:0] DspAddrLoc = 16'h00F2;
  localparam logic [15:0] DspDataLoc = 16'h00F3;

  state_e      state_q;
  logic        last_smp_q;   // 1: most recent completed grant went to the SMP
  logic [7:0]  dspaddr_q;
  logic [7:0]  smp_di_q;
  logic [7:0]  dsp_di_q;
  logic        dsp_ack_q;
  logic        reg_wr_q;
  logic [7:0]  reg_wdata_q;
  logic        mem_req_q;
  logic [15:0] mem_a_q;
  logic        mem_we_q;
  logic [7:0]  mem_wdata_q;

  logic        smp_is_addr;
  logic        smp_is_data;
  logic        smp_write;
  logic        dsp_win;

  // Request decode and tie-break for the idle state.
  always_comb begin
    smp_is_addr = (bus_io.SMP_A == DspAddrLoc);
    smp_is_data = (bus_io.SMP_A == DspDataLoc);
    smp_write   = ~bus_io.SMP_WE_N;
    // DSP_REQ is still high in the DSP_ACK cycle for the request just served;
    // it must not be mistaken for a fresh request.
    dsp_win     = bus_io.DSP_REQ & ~dsp_ack_q & (last_smp_q | ~bus_io.SMP_REQ);
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      last_smp_q  <= 1'b1;
      dspaddr_q   <= 8'h00;
      smp_di_q    <= 8'h00;
      dsp_di_q    <= 8'h00;
      dsp_ack_q   <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_wdata_q <= 8'h00;
      mem_req_q   <= 1'b0;
      mem_a_q     <= 16'h0000;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
    end else begin
      reg_wr_q  <= 1'b0;
      dsp_ack_q <= 1'b0;

      case (state_q)
        StIdle: begin
          if (dsp_win) begin
            mem_req_q <= 1'b1;
            mem_a_q   <= bus_io.DSP_A;
            mem_we_q  <= 1'b0;
            state_q   <= StMemDsp;
          end else if (bus_io.SMP_REQ) begin
            if (smp_write) begin
              // Window writes also land in RAM, so the RAM copy stays coherent.
              if (smp_is_addr) begin
                dspaddr_q <= bus_io.SMP_DO;
              end
              // Bit 7 of the address latch makes the data port read-only.
              if (smp_is_data && !dspaddr_q[7]) begin
                reg_wr_q    <= 1'b1;
                reg_wdata_q <= bus_io.SMP_DO;
              end
              mem_req_q   <= 1'b1;
              mem_a_q     <= bus_io.SMP_A;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= bus_io.SMP_DO;
              state_q     <= StMemSmp;
            end else if (smp_is_addr) begin
              smp_di_q <= dspaddr_q;
              state_q  <= StSmpDone;
            end else if (smp_is_data) begin
              // REG_ADDR only carries bits 6:0, which gives the mirror for free.
              smp_di_q <= bus_io.REG_RDATA;
              state_q  <= StSmpDone;
            end else begin
              mem_req_q <= 1'b1;
              mem_a_q   <= bus_io.SMP_A;
              mem_we_q  <= 1'b0;
              state_q   <= StMemSmp;
            end
          end
        end

        StMemSmp: begin
          if (bus_io.MEM_ACK) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              smp_di_q <= bus_io.MEM_RDATA;
            end
            state_q <= StSmpDone;
          end
        end

        StMemDsp: begin
          if (bus_io.MEM_ACK) begin
            mem_req_q  <= 1'b0;
            dsp_di_q   <= bus_io.MEM_RDATA;
            dsp_ack_q  <= 1'b1;
            last_smp_q <= 1'b0;
            state_q    <= StIdle;
          end
        end

        StSmpDone: begin
          last_smp_q <= 1'b1;
          state_q    <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output wiring; SMP_WAIT is the only combinational output.
  assign bus_io.SMP_WAIT  = bus_io.SMP_REQ & (state_q != StSmpDone);
  assign bus_io.SMP_DI    = smp_di_q;
  assign bus_io.DSP_ACK   = dsp_ack_q;
  assign bus_io.DSP_DI    = dsp_di_q;
  assign bus_io.REG_ADDR  = dspaddr_q[6:0];
  assign bus_io.REG_WR    = reg_wr_q;
  assign bus_io.REG_WDATA = reg_wdata_q;
  assign bus_io.MEM_REQ   = mem_req_q;
  assign bus_io.MEM_A     = mem_a_q;
  assign bus_io.MEM_WE    = mem_we_q;
  assign bus_io.MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_apu_aram_arbiter.sv
// Directed bench for apu_aram_arbiter: behavioural RAM with programmable latency,
// a fixed-pattern DSP register file, and hand-computed expectations.
module tb_apu_aram_arbiter;

  logic clk;
  logic rst_n;

  apu_aram_arbiter_if bus ();

  apu_aram_arbiter dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DSP register file model: reg[i] = $A0 ^ i
  assign bus.REG_RDATA = 8'hA0 ^ {1'b0, bus.REG_ADDR};

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem_model [0:65535];
  int          mem_lat = 0;
  int          lat_cnt = 0;
  bit          stray_ack = 1'b0;
  bit          memreq_prev = 1'b0;
  int          mem_req_cnt = 0;
  int          dsp_ack_cnt = 0;
  int          reg_wr_cnt = 0;
  logic [6:0]  reg_addr_seen = '0;
  logic [7:0]  reg_wdata_seen = '0;
  logic        reg_wr_memreq = 1'b0;
  logic [15:0] last_a = '0;
  logic        last_we = 1'b0;
  logic [15:0] ord [0:7];
  int          ord_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder and bus monitor, all on the falling edge.
  initial begin
    bus.MEM_ACK   = 1'b0;
    bus.MEM_RDATA = 8'h00;
    forever begin
      @(negedge clk);
      bus.MEM_ACK = 1'b0;
      if (bus.REG_WR) begin
        reg_wr_cnt++;
        reg_addr_seen  = bus.REG_ADDR;
        reg_wdata_seen = bus.REG_WDATA;
        reg_wr_memreq  = bus.MEM_REQ;
      end
      if (bus.DSP_ACK) dsp_ack_cnt++;
      if (bus.MEM_REQ && !memreq_prev) mem_req_cnt++;
      memreq_prev = bus.MEM_REQ;
      if (stray_ack) begin
        bus.MEM_ACK = 1'b1;
        stray_ack   = 1'b0;
      end else if (bus.MEM_REQ) begin
        if (lat_cnt == mem_lat) begin
          bus.MEM_ACK = 1'b1;
          lat_cnt     = 0;
          last_a      = bus.MEM_A;
          last_we     = bus.MEM_WE;
          if (bus.MEM_WE) mem_model[bus.MEM_A] = bus.MEM_WDATA;
          else bus.MEM_RDATA = mem_model[bus.MEM_A];
          if (ord_n < 8) begin
            ord[ord_n] = bus.MEM_A;
            ord_n++;
          end
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Called at a falling edge; returns at a falling edge with SMP_REQ low.
  task automatic smp_access(input logic we_n, input logic [15:0] a, input logic [7:0] d,
                            output logic [7:0] rd, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    rd    = 8'h00;
    bus.SMP_REQ  = 1'b1;
    bus.SMP_A    = a;
    bus.SMP_DO   = d;
    bus.SMP_WE_N = we_n;
    for (int i = 0; i < 80 && !done; i++) begin
      #1;
      if (!bus.SMP_WAIT) begin
        done = 1'b1;
        rd   = bus.SMP_DI;
      end else begin
        waits++;
        @(negedge clk);
      end
    end
    check_eq("smp_done", 32'(done), 32'd1);
    @(negedge clk);
    bus.SMP_REQ = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge of the DSP_ACK cycle.
  task automatic dsp_read(input logic [15:0] a, input bit drop_after_grant,
                          output logic [7:0] rd, output bit got);
    got = 1'b0;
    rd  = 8'h00;
    bus.DSP_REQ = 1'b1;
    bus.DSP_A   = a;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (drop_after_grant && bus.MEM_REQ && !bus.MEM_WE && bus.MEM_A == a) bus.DSP_REQ = 1'b0;
      if (bus.DSP_ACK) begin
        got = 1'b1;
        rd  = bus.DSP_DI;
      end
    end
    bus.DSP_REQ = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.SMP_REQ = 1'b0;
    bus.DSP_REQ = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] rd;
  logic [7:0] d0;
  logic [7:0] d1;
  int         waits;
  int         w2;
  int         cnt_a;
  int         cnt_b;
  bit         g0;
  bit         g1;

  initial begin
    rst_n        = 1'b0;
    bus.SMP_REQ  = 1'b0;
    bus.SMP_A    = '0;
    bus.SMP_DO   = '0;
    bus.SMP_WE_N = 1'b1;
    bus.DSP_REQ  = 1'b0;
    bus.DSP_A    = '0;
    mem_model[16'h1234] = 8'h5A;
    mem_model[16'h2000] = 8'h11;
    mem_model[16'h2001] = 8'h22;
    mem_model[16'h3000] = 8'h33;
    mem_model[16'hFFFF] = 8'h9E;
    do_reset();

    // Reset state
    #1;
    check_eq("rst_smp_wait", 32'(bus.SMP_WAIT), 32'd0);
    check_eq("rst_mem_req", 32'(bus.MEM_REQ), 32'd0);
    check_eq("rst_mem_we_a_wd", {15'd0, bus.MEM_WE, bus.MEM_A}, 32'd0);
    check_eq("rst_mem_wdata", 32'(bus.MEM_WDATA), 32'd0);
    check_eq("rst_strobes", {30'd0, bus.REG_WR, bus.DSP_ACK}, 32'd0);
    check_eq("rst_di", {16'd0, bus.SMP_DI, bus.DSP_DI}, 32'd0);
    check_eq("rst_reg_addr", 32'(bus.REG_ADDR), 32'd0);
    @(negedge clk);

    // SMP read with 3-cycle memory latency
    mem_lat = 3;
    smp_access(1'b1, 16'h1234, 8'h00, rd, waits);
    check_eq("rd1234_data", 32'(rd), 32'h5A);
    check_eq("rd1234_waits", 32'(waits), 32'd5);
    check_eq("rd1234_addr", 32'(last_a), 32'h1234);
    check_eq("rd1234_we", 32'(last_we), 32'd0);

    // Register window: address latch then data write
    mem_lat = 0;
    cnt_a = reg_wr_cnt;
    smp_access(1'b0, 16'h00F2, 8'h6C, rd, waits);
    smp_access(1'b0, 16'h00F3, 8'h80, rd, waits);
    check_eq("f3wr_pulses", 32'(reg_wr_cnt - cnt_a), 32'd1);
    check_eq("f3wr_addr", 32'(reg_addr_seen), 32'h6C);
    check_eq("f3wr_data", 32'(reg_wdata_seen), 32'h80);
    check_eq("f3wr_with_memreq", 32'(reg_wr_memreq), 32'd1);
    check_eq("ram_f2", 32'(mem_model[16'h00F2]), 32'h6C);
    check_eq("ram_f3", 32'(mem_model[16'h00F3]), 32'h80);
    cnt_a = mem_req_cnt;
    smp_access(1'b1, 16'h00F2, 8'h00, rd, waits);
    check_eq("f2rd_data", 32'(rd), 32'h6C);
    check_eq("f2rd_waits", 32'(waits), 32'd1);
    check_eq("f2rd_no_mem", 32'(mem_req_cnt - cnt_a), 32'd0);

    // Other $00Fx addresses and $FFFF are ordinary RAM
    smp_access(1'b0, 16'h00F1, 8'h77, rd, waits);
    check_eq("ram_f1", 32'(mem_model[16'h00F1]), 32'h77);
    check_eq("f1_we", 32'(last_we), 32'd1);
    smp_access(1'b1, 16'hFFFF, 8'h00, rd, waits);
    check_eq("rd_ffff", 32'(rd), 32'h9E);

    // Read-only window when DSPADDR[7]=1, with mirrored read
    smp_access(1'b0, 16'h00F2, 8'h8C, rd, waits);
    cnt_a = reg_wr_cnt;
    cnt_b = mem_req_cnt;
    smp_access(1'b0, 16'h00F3, 8'h55, rd, waits);
    check_eq("f3ro_no_regwr", 32'(reg_wr_cnt - cnt_a), 32'd0);
    check_eq("f3ro_mem_issued", 32'(mem_req_cnt - cnt_b), 32'd1);
    check_eq("f3ro_ram", 32'(mem_model[16'h00F3]), 32'h55);
    smp_access(1'b1, 16'h00F3, 8'h00, rd, waits);
    check_eq("f3rd_mirror", 32'(rd), 32'hAC);
    check_eq("f3rd_waits", 32'(waits), 32'd1);

    // DSP request withdrawn before it could be granted
    mem_lat = 4;
    cnt_a = dsp_ack_cnt;
    cnt_b = mem_req_cnt;
    fork
      smp_access(1'b1, 16'h1234, 8'h00, rd, waits);
      begin
        @(negedge clk);
        bus.DSP_REQ = 1'b1;
        bus.DSP_A   = 16'h4444;
        repeat (2) @(negedge clk);
        bus.DSP_REQ = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check_eq("dspdrop_waits", 32'(waits), 32'd6);
    check_eq("dspdrop_no_ack", 32'(dsp_ack_cnt - cnt_a), 32'd0);
    check_eq("dspdrop_one_mem", 32'(mem_req_cnt - cnt_b), 32'd1);

    // Contention right after reset: DSP, SMP, DSP
    do_reset();
    mem_lat = 0;
    ord_n   = 0;
    fork
      begin
        dsp_read(16'h2000, 1'b0, d0, g0);
        dsp_read(16'h2001, 1'b0, d1, g1);
      end
      smp_access(1'b1, 16'h3000, 8'h00, rd, w2);
    join
    check_eq("fair_n", 32'(ord_n), 32'd3);
    check_eq("fair_0", 32'(ord[0]), 32'h2000);
    check_eq("fair_1", 32'(ord[1]), 32'h3000);
    check_eq("fair_2", 32'(ord[2]), 32'h2001);
    check_eq("fair_dsp_data", {16'd0, d0, d1}, 32'h1122);
    check_eq("fair_dsp_acks", {30'd0, g0, g1}, 32'd3);
    check_eq("fair_smp_data", 32'(rd), 32'h33);
    check_eq("fair_smp_waits", 32'(w2), 32'd4);

    // DSP drops its request after grant: cycle still completes
    @(negedge clk);
    mem_lat = 2;
    dsp_read(16'h2001, 1'b1, d0, g0);
    check_eq("dsplate_ack", 32'(g0), 32'd1);
    check_eq("dsplate_data", 32'(d0), 32'h22);

    // Reset mid DSP transaction, then a stray MEM_ACK
    @(negedge clk);
    mem_lat     = 50;
    bus.DSP_REQ = 1'b1;
    bus.DSP_A   = 16'h4000;
    for (int i = 0; i < 20 && !bus.MEM_REQ; i++) @(negedge clk);
    check_eq("midrst_granted", 32'(bus.MEM_REQ), 32'd1);
    cnt_a       = dsp_ack_cnt;
    rst_n       = 1'b0;
    bus.DSP_REQ = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_memreq_drop", 32'(bus.MEM_REQ), 32'd0);
    stray_ack = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("midrst_no_ack", 32'(dsp_ack_cnt - cnt_a), 32'd0);
    check_eq("midrst_memreq_idle", 32'(bus.MEM_REQ), 32'd0);
    smp_access(1'b1, 16'h00F2, 8'h00, rd, waits);
    check_eq("midrst_idle_waits", 32'(waits), 32'd1);
    check_eq("midrst_dspaddr", 32'(rd), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apu_aram_arbiter.md
# apu_aram_arbiter

Arbitrates the 64 KB audio RAM between the SMP bus (A/DO/WE_N/DI) and the DSP's sample/echo fetch port, and decodes the DSP register window at $00F2/$00F3. Sits directly downstream of the SMP. It turns SMP bus cycles into request/acknowledge transactions on a single-port external memory and stalls the SMP through its ENABLE input while a transaction is outstanding. DSP fetches have hard real-time priority. The SMP is guaranteed progress by alternation.

## Interface
Parameters:
- none.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous, active-low reset.
- SMP_REQ  in  1  SMP bus cycle pending; held with SMP_A/SMP_DO/SMP_WE_N stable while SMP_WAIT=1.
- SMP_A  in  16  SMP address.
- SMP_DO  in  8  SMP write data.
- SMP_WE_N  in  1  0 = write.
- SMP_DI  out  8  read data to SMP; registered; valid when SMP_REQ=1 and SMP_WAIT=0.
- SMP_WAIT  out  1  stall; drives SMP ENABLE low.
- DSP_REQ  in  1  DSP read request; level, held until DSP_ACK.
- DSP_A  in  16  DSP read address.
- DSP_ACK  out  1  one-cycle pulse; DSP_DI valid that cycle.
- DSP_DI  out  8  DSP read data, registered.
- REG_ADDR  out  7  DSP register index = DSPADDR[6:0].
- REG_WR  out  1  one-cycle DSP register write strobe.
- REG_WDATA  out  8  DSP register write data.
- REG_RDATA  in  8  DSP register read data, combinational from DSP.
- MEM_REQ  out  1  memory request; level until MEM_ACK.
- MEM_A  out  16  memory address.
- MEM_WE  out  1  1 = write.
- MEM_WDATA  out  8  memory write data.
- MEM_RDATA  in  8  memory read data, valid with MEM_ACK.
- MEM_ACK  in  1  one-cycle completion pulse.

## Operation
- States: IDLE, MEM_SMP, MEM_DSP, SMP_DONE.
- IDLE, DSP_REQ=1, and (last grant was SMP or no SMP request): issue DSP read, go to MEM_DSP.
- Otherwise, IDLE with SMP_REQ=1:
  - $00F2 write: latch DSPADDR[7:0] <= SMP_DO. Also write RAM via MEM_SMP.
  - $00F3 write: if DSPADDR[7]=0, pulse REG_WR with REG_WDATA=SMP_DO. Also write RAM via MEM_SMP.
  - $00F2 read: SMP_DI <= DSPADDR. Go to SMP_DONE, no memory access.
  - $00F3 read: SMP_DI <= REG_RDATA. Go to SMP_DONE, no memory access.
  - All other addresses, including other $00F0-$00FF: memory read or write via MEM_SMP.
- DSPADDR[7]=1: $00F3 writes are ignored. $00F3 reads return the register at index DSPADDR[6:0] (hardware mirror).
- MEM_SMP: on MEM_ACK, SMP_DI <= MEM_RDATA (reads), go to SMP_DONE.
- MEM_DSP: on MEM_ACK, DSP_DI <= MEM_RDATA, DSP_ACK=1 next cycle, go to IDLE.
- SMP_DONE: lasts one cycle, SMP_WAIT=0. Return to IDLE. Records last grant = SMP.
- MEM_DSP completion records last grant = DSP.
- Fairness: when both requests are pending, grants alternate. DSP wins whenever last grant was SMP.
- SMP_WAIT = SMP_REQ & (state != SMP_DONE), combinational.
- MEM_A/MEM_WE/MEM_WDATA are registered at grant and held until MEM_ACK.

## Timing
- Reset values:
  - state=IDLE, last grant=SMP (DSP wins first tie).
  - DSPADDR=0, SMP_DI=0, DSP_DI=0.
  - MEM_REQ=0, MEM_WE=0, MEM_A=0, MEM_WDATA=0.
  - REG_WR=0, DSP_ACK=0.
  - SMP_WAIT follows its equation.
- Register-window read: SMP_REQ at cycle t → SMP_DONE at t+1 (SMP_WAIT=0, SMP_DI valid).
- Memory access: MEM_REQ rises at t+1. MEM_ACK at cycle m → SMP_DONE or DSP_ACK at m+1.
- REG_WR pulses at t+1 for a $00F3 write, concurrent with MEM_REQ.
- The DSPADDR update from a $00F2 write is visible to an $00F3 access granted at t+1 or later.
- MEM_ACK while MEM_REQ=0 is ignored.
- A DSP_REQ that drops before grant is not serviced. A DSP_REQ dropped after grant still completes the memory cycle, and DSP_ACK still pulses.
- Reset mid-transaction: MEM_REQ drops the next cycle. A MEM_ACK in flight is discarded. Returns to IDLE with no acknowledgements.
- Address arithmetic is 16-bit with no wrap handling; $FFFF is an ordinary address. The IPL overlay is resolved upstream.

## Test plan
- Reset, then SMP read $1234, memory returns $5A with MEM_ACK 3 cycles after MEM_REQ → SMP_WAIT high 5 cycles, SMP_DI=$5A in the SMP_DONE cycle; MEM_WE=0, MEM_A=$1234.
- SMP writes $6C to $00F2, then $80 to $00F3 → REG_WR pulse with REG_ADDR=$6C, REG_WDATA=$80; RAM $00F2 and $00F3 written; a subsequent $00F2 read returns $6C with no MEM_REQ.
- DSPADDR=$8C, SMP writes $00F3 → no REG_WR, RAM write still issued; an $00F3 read returns REG_RDATA of index $0C.
- DSP_REQ and SMP_REQ both asserted in IDLE after reset, zero-latency memory → DSP served first, then SMP, then DSP again if still requesting; neither port waits more than one other transaction.
- RST_N low for 1 cycle while MEM_REQ=1 for a DSP read, followed by a stray MEM_ACK → DSP_ACK never pulses, state=IDLE, MEM_REQ=0.
